gpio_walk_seq: RTL

Self-checking GPIO test sequencer for the 32-pin board header. It drives one pattern per step onto the pins and holds it long enough to be visible. It then samples the pins back through an internal synchronizer and compares them against the driven value, which supports external loopback or pad readback. It sits between the top-level pad ring and the status/LED logic, replacing a free-running `seq` counter with a start/done-controlled, error-reporting sequence.

---
 rtl/gpio_walk_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/gpio_walk_seq.sv
// rtl/gpio_walk_seq.sv - start/done controlled GPIO pattern sequencer with loopback check
//
// Purpose: drives one test pattern per step onto the GPIO pins and holds it for
// HOLD_CYCLES cycles. It then compares the 2-flop synchronized pad readback against
// the driven value and reports sticky error status.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        begin a run (IDLE only)
//   abort_i        synchronous stop back to IDLE
//   mode_i         00 walking-1, 01 walking-0, 10 all-toggle, 11 checkerboard
//   loop_i         restart automatically after DONE
//   check_mask_i   1 = pin excluded from the compare
//   gpio_in_i      asynchronous pad readback
//   gpio_out_o     registered drive pattern
//   gpio_oe_o      all-ones while driving
//   busy_o         high in DRIVE/HOLD/CHECK/DONE
//   done_o         one-cycle pulse at the end of each pass
//   seq_o          current step index
//   err_o          sticky mismatch flag since the last start
//   err_pin_o      lowest failing unmasked pin of the first failing step
//   err_count_o    failing steps, saturating at 0xFFFF
module gpio_walk_seq #(
    parameter int  NUM_PINS    = 32,
    parameter int  HOLD_CYCLES = 12_000_000,
    localparam int PW          = $clog2(NUM_PINS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [1:0]          mode_i,
    input  logic                loop_i,
    input  logic [NUM_PINS-1:0] check_mask_i,
    input  logic [NUM_PINS-1:0] gpio_in_i,
    output logic [NUM_PINS-1:0] gpio_out_o,
    output logic [NUM_PINS-1:0] gpio_oe_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [PW-1:0]       seq_o,
    output logic                err_o,
    output logic [PW-1:0]       err_pin_o,
    output logic [15:0]         err_count_o
);

    localparam int            HW        = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] SEQ_LAST  = PW'(NUM_PINS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t              state_q;
    logic [NUM_PINS-1:0] sync1_q, sync2_q;
    logic [NUM_PINS-1:0] gpio_out_q, gpio_oe_q;
    logic [HW-1:0]       hold_cnt_q;
    logic [PW-1:0]       seq_q, err_pin_q;
    logic [15:0]         err_count_q;
    logic                busy_q, done_q, err_q;

    logic [NUM_PINS-1:0] pattern_d, pattern0_d, miss_d;
    logic [PW-1:0]       miss_pin_d;

    // Pattern for step k, built bit by bit so any NUM_PINS truncates naturally.
    function automatic logic [NUM_PINS-1:0] pattern_f(input logic [1:0] m, input logic [PW-1:0] k);
        logic [NUM_PINS-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            case (m)
                2'b00:   p[i] = (i == int'(k));
                2'b01:   p[i] = (i != int'(k));
                2'b10:   p[i] = ~k[0];
                default: p[i] = ((i % 2) == int'(k[0]));  // 0x5555.. even, 0xAAAA.. odd
            endcase
        end
        return p;
    endfunction

    // Index of the lowest set bit; scanning downward lets the lowest one win.
    function automatic logic [PW-1:0] lowest_f(input logic [NUM_PINS-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    assign pattern_d  = pattern_f(mode_i, seq_q);
    assign pattern0_d = pattern_f(mode_i, '0);
    assign miss_d     = (sync2_q ^ gpio_out_q) & ~check_mask_i;
    assign miss_pin_d = lowest_f(miss_d);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gpio_out_q  <= '0;
            gpio_oe_q   <= '0;
            hold_cnt_q  <= '0;
            seq_q       <= '0;
            err_pin_q   <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && state_q != ST_IDLE) begin
                state_q    <= ST_IDLE;
                gpio_out_q <= '0;
                gpio_oe_q  <= '0;
                seq_q      <= '0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            err_q       <= 1'b0;
                            err_pin_q   <= '0;
                            err_count_q <= '0;
                            seq_q       <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_DRIVE;
                        end
                    end
                    ST_DRIVE: begin
                        gpio_out_q <= pattern_d;
                        gpio_oe_q  <= '1;
                        hold_cnt_q <= '0;
                        state_q    <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q <= ST_CHECK;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HW'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (miss_d != '0) begin
                            if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
                            if (!err_q) err_pin_q <= miss_pin_d;
                            err_q <= 1'b1;
                        end
                        if (seq_q == SEQ_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            seq_q   <= seq_q + PW'(1);
                            state_q <= ST_DRIVE;
                        end
                    end
                    ST_DONE: begin
                        if (loop_i) begin
                            // DONE doubles as step 0's DRIVE so a looped pass is
                            // exactly NUM_PINS steps long with no extra cycle.
                            seq_q      <= '0;
                            gpio_out_q <= pattern0_d;
                            hold_cnt_q <= '0;
                            state_q    <= ST_HOLD;
                        end else begin
                            gpio_oe_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign gpio_out_o  = gpio_out_q;
    assign gpio_oe_o   = gpio_oe_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign seq_o       = seq_q;
    assign err_o       = err_q;
    assign err_pin_o   = err_pin_q;
    assign err_count_o = err_count_q;

endmodule
